// File: rtl/fetch_pkg.sv
// Shared types and constants for the CPU fetch front end.
//   ILEN/PC_W   : instruction and PC widths
//   PC_STEP     : byte increment between sequential instruction words
//   fetch_tag_t : in-flight read tag {valid, pc}
//   fetch_entry_t: instruction queue payload {ins, pc}
//   fetch_state_t: RUN/HALT
package fetch_pkg;

   localparam int unsigned ILEN    = 16;
   localparam int unsigned PC_W    = 16;
   localparam int unsigned PC_STEP = 2;
   localparam int unsigned ENTRY_W = ILEN + PC_W;

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
   } fetch_tag_t;

   typedef struct packed {
      logic [ILEN-1:0] ins;
      logic [PC_W-1:0] pc;
   } fetch_entry_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   // Saturating 32-bit add for event counters.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched instructions for decode.
//   clk, rst   : clock, async active-high reset
//   flush      : empty the queue (wins over push/pop)
//   push       : write push_data at the tail
//   pop        : drop the head entry
//   push_data  : tail write data
//   head       : oldest entry (stable while empty)
//   count      : number of valid entries
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = ENTRY_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // Pointer advance with wrap for non power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (cnt == CNT_W'(DEPTH));
   assign do_pop  = pop && (cnt != '0);
   assign do_push = push && (!full || do_pop);

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign count = cnt;

   // The credit scheme upstream must never overfill the queue.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, fixed-latency imem read pipe, instruction
// queue and valid/ready hand-off to decode, with redirect and halt.
// Optional macro FETCH_PERF_EN adds perf_issued/perf_squashed counters.
//   clk, rst        : clock, async active-high reset
//   redirect_valid  : restart at redirect_pc, squash queue and in-flight reads
//   redirect_pc     : new PC (bit 0 forced to 0)
//   halt_req        : enter HALT (sticky until reset)
//   imem_raddr      : word address pc[15:1]
//   imem_rdata      : read data, MEM_LATENCY cycles after its address
//   out_valid/out_ready/out_ins/out_pc : decode hand-off
//   halted          : unit is in HALT
//   perf_issued, perf_squashed (FETCH_PERF_EN only): saturating event counts
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter logic [15:0] PC_RESET    = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   input  logic        halt_req,
   output logic [14:0] imem_raddr,
   input  logic [15:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_ins,
   output logic [15:0] out_pc,
   output logic        halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_squashed
`endif
);

   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

   if (MEM_LATENCY < 1 || QUEUE_DEPTH < MEM_LATENCY + 2) begin : g_bad_params
      $error("fetch_unit: need MEM_LATENCY >= 1 and QUEUE_DEPTH >= MEM_LATENCY+2");
   end

   fetch_state_t     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   fetch_tag_t       pipe_q [MEM_LATENCY];
   fetch_tag_t       pipe_d [MEM_LATENCY];

   logic [CNT_W-1:0] q_count;
   logic [CNT_W-1:0] inflight_count;
   logic [CNT_W:0]   occupancy;
   logic             run;
   logic             credit_ok;
   logic             halt_now;
   logic             redir_now;
   logic             issue;
   logic             push;
   logic             pop;
   logic             flush;
   fetch_tag_t       ret_tag;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;
   logic             unused_redirect_lsb;

   assign unused_redirect_lsb = redirect_pc[0];

   // Count reads still travelling through the memory pipe.
   always_comb begin
      inflight_count = '0;
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
         inflight_count = inflight_count + CNT_W'(pipe_q[i].valid);
      end
   end

   // Credit covers queued plus in-flight words; a same-cycle pop frees nothing.
   assign occupancy = {1'b0, q_count} + {1'b0, inflight_count};
   assign credit_ok = occupancy < (CNT_W+1)'(QUEUE_DEPTH);

   assign run       = (state_q == ST_RUN);
   assign halt_now  = run && halt_req;
   assign redir_now = run && redirect_valid && !halt_req;
   assign flush     = halt_now || redir_now;
   assign issue     = run && !halt_req && !redirect_valid && credit_ok;
   assign ret_tag   = pipe_q[MEM_LATENCY-1];
   assign push      = run && !halt_req && !redirect_valid && ret_tag.valid;

   assign push_entry.ins = imem_rdata;
   assign push_entry.pc  = ret_tag.pc;

   assign out_valid = (q_count != '0) && run && !redirect_valid;
   assign pop       = out_valid && out_ready;

   // Next state, PC and read-tag pipe.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pipe_d  = pipe_q;

      if (halt_now) state_d = ST_HALT;

      if (redir_now)  pc_d = {redirect_pc[15:1], 1'b0};
      else if (issue) pc_d = pc_q + PC_W'(PC_STEP);

      pipe_d[0].valid = issue;
      pipe_d[0].pc    = pc_q;
      for (int i = 1; i < int'(MEM_LATENCY); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      // Squashed reads keep flowing but their data is never captured.
      if (flush) begin
         for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            pipe_d[i].valid = 1'b0;
         end
      end
   end

   // State, PC and tag pipe registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= PC_RESET;
         for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .pop       (pop),
      .push_data (push_entry),
      .head      (head_entry),
      .count     (q_count)
   );

   assign imem_raddr = pc_q[15:1];
   assign out_ins    = head_entry.ins;
   assign out_pc     = head_entry.pc;
   assign halted     = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
   logic [31:0] squash_amt;

   assign squash_amt = 32'(q_count) + 32'(inflight_count);

   // Saturating issue and squash counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued   <= '0;
         perf_squashed <= '0;
      end else begin
         if (issue) perf_issued   <= sat_add32(perf_issued, 32'd1);
         if (flush) perf_squashed <= sat_add32(perf_squashed, squash_amt);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit against a pipelined ROM (mem[a] = 8000|a).
module tb_fetch_unit;

   localparam int unsigned ML = 2;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt_req;
   logic [14:0] imem_raddr;
   logic [15:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_ins;
   logic [15:0] out_pc;
   logic        halted;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_squashed;
`endif

   fetch_unit #(
      .MEM_LATENCY (ML),
      .QUEUE_DEPTH (4),
      .PC_RESET    (16'h0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .imem_raddr     (imem_raddr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_ins        (out_ins),
      .out_pc         (out_pc),
      .halted         (halted)
`ifdef FETCH_PERF_EN
      ,
      .perf_issued    (perf_issued),
      .perf_squashed  (perf_squashed)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pipelined ROM: data for an address appears ML cycles after it is driven.
   logic [14:0] apipe [ML];
   always @(posedge clk) begin
      apipe[0] <= imem_raddr;
      for (int i = 1; i < int'(ML); i++) apipe[i] <= apipe[i-1];
   end
   assign imem_rdata = 16'h8000 | {1'b0, apipe[ML-1]};

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mon_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] model(input logic [15:0] pc);
      logic [15:0] ins;
      ins = 16'h8000 | {1'b0, pc[15:1]};
      return {ins, pc};
   endfunction

   task automatic push_seq(input logic [15:0] start, input int n);
      logic [15:0] pc;
      pc = start;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(model(pc));
         pc = pc + 16'd2;
      end
   endtask

   // Wait for the scoreboard to empty, then stop accepting.
   task automatic drain(input string tag, output int cyc);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (exp_q.size() != 0) begin
         check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      out_ready = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      redirect_valid = 1'b0;
      halt_req = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Every accepted transfer is compared with the scoreboard head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_xfer", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check("xfer_pc",  32'(out_pc),  32'(mon_e[15:0]));
            check("xfer_ins", 32'(out_ins), 32'(mon_e[31:16]));
         end
      end
   end

   initial begin
      int k;
      int cyc;
      logic [14:0] snap;

      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 16'h0000;
      halt_req = 1'b0;
      out_ready = 1'b0;

      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_halted",    32'(halted),    32'd0);
      check("rst_raddr",     32'(imem_raddr), 32'd0);

      // 1: streaming from reset, first valid in cycle 3
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      push_seq(16'h0000, 8);
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (out_valid) break;
         k++;
      end
      check("s1_first_valid_cycle", 32'(k), 32'd3);
      drain("s1", cyc);

      // 2: backpressure fills queue, issue stops at pc 8
      reset_dut();
      repeat (10) @(negedge clk);
      check("s2_raddr_stalled", 32'(imem_raddr), 32'h4);
      check("s2_valid_stalled", 32'(out_valid),  32'd1);
      check("s2_head_pc",       32'(out_pc),     32'h0000);
      check("s2_head_ins",      32'(out_ins),    32'h8000);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      push_seq(16'h0000, 5);
      drain("s2", cyc);
      check("s2_drain_cycles", 32'(cyc), 32'd5);

      // 3: redirect to odd address squashes full queue
      reset_dut();
      repeat (8) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc = 16'h0041;
      out_ready = 1'b1;
      push_seq(16'h0040, 3);
      @(negedge clk);
      check("s3_valid_masked", 32'(out_valid), 32'd0);
      k = 1;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      while (k < 20) begin
         @(negedge clk);
         if (out_valid) break;
         k++;
      end
      check("s3_redirect_latency", 32'(k), 32'd4);
      drain("s3", cyc);

      // 4: back-to-back redirects, last wins
      redirect_valid = 1'b1;
      redirect_pc = 16'h0100;
      @(posedge clk);
      #1;
      redirect_pc = 16'h0200;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      push_seq(16'h0200, 3);
      drain("s4", cyc);

      // 5: PC wrap at the top of memory
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFC;
      out_ready = 1'b1;
      push_seq(16'hFFFC, 4);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      drain("s5", cyc);

      // 6: halt while streaming, redirect ignored in HALT
      redirect_valid = 1'b1;
      redirect_pc = 16'h0300;
      out_ready = 1'b1;
      push_seq(16'h0300, 6);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      drain("s6", cyc);
      halt_req = 1'b1;
      snap = imem_raddr;
      @(negedge clk);
      check("s6_halt_lag", 32'(halted), 32'd0);
      @(posedge clk);
      #1;
      halt_req = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("s6_halted",      32'(halted),     32'd1);
         check("s6_no_valid",    32'(out_valid),  32'd0);
         check("s6_raddr_froze", 32'(imem_raddr), 32'(snap));
      end
      @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc = 16'h0500;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("s6_redir_halted", 32'(halted),     32'd1);
      check("s6_redir_raddr",  32'(imem_raddr), 32'(snap));
      check("s6_redir_valid",  32'(out_valid),  32'd0);

      // 7: reset mid-stream restarts at 0 without stale data
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      reset_dut();
      check("s7_unhalted", 32'(halted), 32'd0);
      out_ready = 1'b1;
      push_seq(16'h0000, 4);
      drain("s7a", cyc);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("s7_rst_valid", 32'(out_valid),  32'd0);
      check("s7_rst_raddr", 32'(imem_raddr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      push_seq(16'h0000, 4);
      drain("s7b", cyc);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
